led_breathe_gen: RTL and testbench



---
 rtl/breathe_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 25 ++
 rtl/led_breathe_gen.sv | 101 ++++++++++
 tb/tb_led_breathe_gen.sv | 139 +++++++++++++
 4 files changed

// File: rtl/breathe_pkg.sv
// Shared types and helpers for the LED breathing duty generator.
package breathe_pkg;

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } phase_t;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

  // l*(l+1) >> w; for l < 2^w the product fits in 2*w bits, so 32-bit math is exact for w <= 16.
  function automatic int unsigned gamma(input int unsigned l, input int unsigned w);
    return (l * (l + 1)) >> w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every DIV enabled clocks, held at zero while disabled.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)                        count <= '0;
    else if (!en)                      count <= '0;
    else if (count == CW'(DIV - 1))    count <= '0;
    else                               count <= count + CW'(1);
  end

  // Gated with en so a tick can't leak out on the cycle en drops.
  assign tick = en & (count == CW'(DIV - 1));

endmodule

// File: rtl/led_breathe_gen.sv
// Triangle/sawtooth brightness ramp whose duty word only updates on a PWM period boundary.
module led_breathe_gen
  import breathe_pkg::*;
#(
  parameter int DUTY_W     = 5,
  parameter int STEP_DIV   = 20833,
  parameter int HOLD_STEPS = 8,
  parameter int GAMMA      = 1
) (
  input  logic              CLK_3p33MHZ,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              MODE,
  input  logic              PERIOD_START,
  output logic [DUTY_W-1:0] DUTY,
  output logic              DUTY_VALID,
  output logic [1:0]        PHASE,
  output logic              OVERRUN
);

  localparam logic [DUTY_W-1:0] MAX = '1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  logic              tick;
  logic              step_pending;
  logic              step_take;
  logic              hold_last;
  phase_t            state, nxt_state;
  logic [DUTY_W-1:0] level, nxt_level, duty_nxt;
  logic [HW-1:0]     hold_cnt, nxt_hold;

  tick_prescaler #(.DIV(STEP_DIV)) u_pre (
    .clk   (CLK_3p33MHZ),
    .rst_n (RST_N),
    .en    (EN),
    .tick  (tick)
  );

  assign step_take = (step_pending | tick) & PERIOD_START & EN;
  assign hold_last = (HOLD_STEPS <= 1) || (int'(hold_cnt) >= HOLD_STEPS - 1);

  always_comb begin
    nxt_state = state;
    nxt_level = level;
    nxt_hold  = hold_cnt + HW'(1);
    if (MODE == MODE_SAW) begin
      nxt_state = RISE;
      nxt_level = level + DUTY_W'(1);
    end else begin
      case (state)
        RISE: begin
          // From MAX this wraps to 0: only reachable right after a sawtooth->triangle switch.
          nxt_level = level + DUTY_W'(1);
          if (nxt_level == MAX) begin
            nxt_state = (HOLD_STEPS == 0) ? FALL : HOLD_HI;
            nxt_hold  = '0;
          end
        end
        HOLD_HI: if (hold_last) nxt_state = FALL;
        FALL: begin
          nxt_level = (level == '0) ? '0 : level - DUTY_W'(1);
          if (nxt_level == '0) begin
            nxt_state = (HOLD_STEPS == 0) ? RISE : HOLD_LO;
            nxt_hold  = '0;
          end
        end
        HOLD_LO: if (hold_last) nxt_state = RISE;
        default: ;
      endcase
    end
  end

  assign duty_nxt = (GAMMA != 0) ? DUTY_W'(gamma(32'(nxt_level), DUTY_W)) : nxt_level;

  always_ff @(posedge CLK_3p33MHZ) begin
    if (!RST_N) begin
      step_pending <= 1'b0;
      state        <= RISE;
      level        <= '0;
      hold_cnt     <= '0;
      DUTY         <= '0;
      DUTY_VALID   <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      DUTY_VALID <= step_take;
      if (!EN || step_take) step_pending <= 1'b0;
      else if (tick)        step_pending <= 1'b1;
      // A second tick arriving before the first was consumed is a lost step.
      if (tick && step_pending && !step_take) OVERRUN <= 1'b1;
      if (step_take) begin
        state    <= nxt_state;
        level    <= nxt_level;
        hold_cnt <= nxt_hold;
        DUTY     <= duty_nxt;
      end
    end
  end

  assign PHASE = state;

endmodule

// File: tb/tb_led_breathe_gen.sv
// Randomized self-checking bench: plain and gamma-shaped instances against a cycle model.
module tb_led_breathe_gen;

  localparam int W    = 3;
  localparam int DIV  = 4;
  localparam int HOLD = 2;
  localparam int MAXL = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0, en = 1'b0, mode = 1'b1, ps = 1'b1;
  logic [W-1:0] duty0, duty1;
  logic         vld0, vld1, ovr0, ovr1;
  logic [1:0]   ph0, ph1;

  always #5 clk = ~clk;

  led_breathe_gen #(.DUTY_W(W), .STEP_DIV(DIV), .HOLD_STEPS(HOLD), .GAMMA(0)) dut (
    .CLK_3p33MHZ(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .PERIOD_START(ps),
    .DUTY(duty0), .DUTY_VALID(vld0), .PHASE(ph0), .OVERRUN(ovr0));

  led_breathe_gen #(.DUTY_W(W), .STEP_DIV(DIV), .HOLD_STEPS(HOLD), .GAMMA(1)) dut_g (
    .CLK_3p33MHZ(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .PERIOD_START(ps),
    .DUTY(duty1), .DUTY_VALID(vld1), .PHASE(ph1), .OVERRUN(ovr1));

  int n_chk = 0, n_err = 0;
  int gam [8] = '{0, 0, 0, 1, 2, 3, 5, 7};

  // Reference state: enabled-cycle phase within the step period, pending flag, ramp position.
  int m_cnt, m_pend, m_level, m_ph, m_hc, m_ovr, m_vld;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_step();
    if (mode == 1'b0) begin
      m_level = (m_level + 1) % (MAXL + 1);
      m_ph    = 0;
    end else begin
      case (m_ph)
        0: begin
          m_level = (m_level == MAXL) ? 0 : m_level + 1;
          if (m_level == MAXL) begin m_ph = 1; m_hc = 0; end
        end
        1: begin if (m_hc == HOLD - 1) m_ph = 2; m_hc++; end
        2: begin
          m_level = (m_level > 0) ? m_level - 1 : 0;
          if (m_level == 0) begin m_ph = 3; m_hc = 0; end
        end
        default: begin if (m_hc == HOLD - 1) m_ph = 0; m_hc++; end
      endcase
    end
  endtask

  task automatic ref_edge();
    bit tk, take;
    if (!rst_n) begin
      m_cnt = 0; m_pend = 0; m_level = 0; m_ph = 0; m_hc = 0; m_ovr = 0; m_vld = 0;
    end else begin
      tk   = en && (m_cnt == DIV - 1);
      take = en && ps && (m_pend != 0 || tk);
      m_vld = take;
      if (take) ref_step();
      if (tk && m_pend != 0 && !take) m_ovr = 1;
      if (!en || take) m_pend = 0;
      else if (tk)     m_pend = 1;
      m_cnt = en ? (m_cnt + 1) % DIV : 0;
    end
  endtask

  task automatic cyc();
    ref_edge();
    @(posedge clk);
    #1;
    chk("duty",  int'(duty0), m_level);
    chk("gduty", int'(duty1), gam[m_level]);
    chk("valid", int'(vld0),  m_vld);
    chk("gvalid", int'(vld1), m_vld);
    chk("phase", int'(ph0),   m_ph);
    chk("ovr",   int'(ovr0),  m_ovr);
    chk("govr",  int'(ovr1),  m_ovr);
  endtask

  initial begin
    int k;
    int rate;
    rst_n = 0; en = 0; mode = 1; ps = 1;
    repeat (3) cyc();

    // Full triangle period with holds, then sawtooth.
    rst_n = 1; en = 1;
    repeat (80) cyc();
    mode = 0;
    repeat (48) cyc();

    // Switch to triangle while sitting at MAX in RISE: next step wraps to 0.
    k = 0;
    while (!(m_level == MAXL && m_ph == 0) && k < 64) begin cyc(); k++; end
    chk("reach_max", int'(k < 64), 1);
    mode = 1;
    repeat (40) cyc();

    // Sparse period starts: lost steps must raise OVERRUN.
    for (int i = 0; i < 60; i++) begin ps = (i % 10 == 0); cyc(); end
    ps = 1;

    // Freeze with EN low mid-ramp.
    rst_n = 0; cyc(); rst_n = 1;
    repeat (17) cyc();
    en = 0; repeat (20) cyc();
    en = 1; repeat (12) cyc();

    // Reset during FALL at level 6.
    k = 0;
    while (!(m_level == 6 && m_ph == 2) && k < 200) begin cyc(); k++; end
    chk("reach_fall6", int'(k < 200), 1);
    rst_n = 0; cyc(); rst_n = 1;
    repeat (8) cyc();

    // Randomized traffic.
    rate = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rate = $urandom_range(0, 6);
      rst_n = ($urandom_range(0, 499) != 0);
      en    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      ps    = ($urandom_range(0, rate) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
